// File: rtl/mdu.sv
// Iterative RV64 multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Division by zero and signed overflow complete on a one-cycle fast path.
package mdu_pkg;
    typedef logic [63:0] word_t;
    typedef enum logic [3:0] {
        MDU_NOP, MDU_MUL, MDU_MULW,
        MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU,
        MDU_DIVW, MDU_DIVUW, MDU_REMW, MDU_REMUW
    } mdu_op_t;
endpackage

module mdu
    import mdu_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    valid,
    input  mdu_op_t op,
    input  word_t   a,
    input  word_t   b,
    input  logic    flush,
    output logic    ready,
    output logic    busy,
    output logic    done,
    output word_t   result
);
    typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, DONE} state_t;

    state_t     state_q, state_d;
    logic [6:0] cnt_q, cnt_d;
    word_t      acc_q, acc_d;   // product accumulator / partial remainder
    word_t      opa_q, opa_d;   // multiplicand / dividend-quotient shift register
    word_t      opb_q, opb_d;   // multiplier / divisor magnitude
    logic       w_q, w_d, rem_sel_q, rem_sel_d, neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
    logic       done_q, done_d;
    word_t      result_q, result_d;

    logic       accept, is_mul, is_w, is_signed, is_rem, a_neg, b_neg, div0, ovf, ge;
    word_t      sa, sb, mag_a, mag_b, fast_val, fast_res, mul_acc, mul_res;
    word_t      quo_nxt, rem_nxt, quo_s, rem_s, pick, div_res;
    logic [64:0] shifted, diff;

    assign ready  = (state_q == IDLE);
    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign result = result_q;

    always_comb begin
        accept    = ready && valid && (op != MDU_NOP) && !flush;
        is_mul    = (op == MDU_MUL) || (op == MDU_MULW);
        is_w      = (op == MDU_MULW) || (op == MDU_DIVW) || (op == MDU_DIVUW) ||
                    (op == MDU_REMW) || (op == MDU_REMUW);
        is_signed = (op == MDU_DIV) || (op == MDU_REM) || (op == MDU_DIVW) || (op == MDU_REMW);
        is_rem    = (op == MDU_REM) || (op == MDU_REMU) || (op == MDU_REMW) || (op == MDU_REMUW);
        if (is_w) begin
            sa = is_signed ? {{32{a[31]}}, a[31:0]} : {32'b0, a[31:0]};
            sb = is_signed ? {{32{b[31]}}, b[31:0]} : {32'b0, b[31:0]};
        end else begin
            sa = a;
            sb = b;
        end
        a_neg    = is_signed && sa[63];
        b_neg    = is_signed && sb[63];
        mag_a    = a_neg ? -sa : sa;
        mag_b    = b_neg ? -sb : sb;
        div0     = (sb == '0);
        ovf      = is_signed && (sb == '1) &&
                   (sa == (is_w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
        fast_val = div0 ? (is_rem ? sa : '1) : (is_rem ? '0 : sa);
        fast_res = is_w ? {{32{fast_val[31]}}, fast_val[31:0]} : fast_val;
    end

    always_comb begin
        mul_acc = opb_q[0] ? acc_q + opa_q : acc_q;
        mul_res = w_q ? {{32{mul_acc[31]}}, mul_acc[31:0]} : mul_acc;
        // Remainder stays below the divisor, so the shifted value fits 65 bits and
        // diff[64] is a clean borrow.
        shifted = {acc_q, opa_q[63]};
        diff    = shifted - {1'b0, opb_q};
        ge      = !diff[64];
        quo_nxt = {opa_q[62:0], ge};
        rem_nxt = ge ? diff[63:0] : shifted[63:0];
        quo_s   = neg_quo_q ? -quo_nxt : quo_nxt;
        rem_s   = neg_rem_q ? -rem_nxt : rem_nxt;
        pick    = rem_sel_q ? rem_s : quo_s;
        div_res = w_q ? {{32{pick[31]}}, pick[31:0]} : pick;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        w_d       = w_q;
        rem_sel_d = rem_sel_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        done_d    = 1'b0;
        result_d  = result_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    w_d       = is_w;
                    rem_sel_d = is_rem;
                    neg_quo_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    cnt_d     = is_w ? 7'd32 : 7'd64;
                    acc_d     = '0;
                    if (is_mul) begin
                        state_d = MUL_RUN;
                        opa_d   = sa;
                        opb_d   = sb;
                    end else if (div0 || ovf) begin
                        state_d  = DONE;
                        done_d   = 1'b1;
                        result_d = fast_res;
                    end else begin
                        state_d = DIV_RUN;
                        opa_d   = is_w ? {mag_a[31:0], 32'b0} : mag_a;
                        opb_d   = mag_b;
                    end
                end
            end
            MUL_RUN: begin
                acc_d = mul_acc;
                opa_d = opa_q << 1;
                opb_d = opb_q >> 1;
                cnt_d = cnt_q - 7'd1;
                if (cnt_q == 7'd1) begin
                    state_d  = DONE;
                    done_d   = 1'b1;
                    result_d = mul_res;
                end
            end
            DIV_RUN: begin
                acc_d = rem_nxt;
                opa_d = quo_nxt;
                cnt_d = cnt_q - 7'd1;
                if (cnt_q == 7'd1) begin
                    state_d  = DONE;
                    done_d   = 1'b1;
                    result_d = div_res;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d  = IDLE;
            done_d   = 1'b0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            w_q       <= 1'b0;
            rem_sel_q <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            w_q       <= w_d;
            rem_sel_q <= rem_sel_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            done_q    <= done_d;
            result_q  <= result_d;
        end
    end
endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: arithmetic reference model plus per-cycle compare of done/ready/busy/result.
module tb_mdu;
    import mdu_pkg::*;

    logic    clk = 1'b0;
    logic    reset, valid, flush;
    mdu_op_t op;
    word_t   a, b;
    logic    ready, busy, done;
    word_t   result;

    mdu dut (
        .clk(clk), .reset(reset), .valid(valid), .op(op), .a(a), .b(b), .flush(flush),
        .ready(ready), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    int    cyc = 0;
    int    n_assert = 0;
    int    n_fail = 0;
    int    exp_done_cyc, exp_ready_cyc, exp_reset_cyc;
    word_t pending, model_result;
    logic  chk_en = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input word_t act, input word_t exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    function automatic word_t model(input mdu_op_t o, input word_t x, input word_t y);
        logic [31:0] x32, y32, r32;
        logic        wide;
        x32  = x[31:0];
        y32  = y[31:0];
        r32  = '0;
        wide = 1'b1;
        case (o)
            MDU_MUL:  return x * y;
            MDU_DIV:  if (y == 0) return '1;
                      else if (x == 64'h8000_0000_0000_0000 && y == '1) return x;
                      else return $signed(x) / $signed(y);
            MDU_REM:  if (y == 0) return x;
                      else if (x == 64'h8000_0000_0000_0000 && y == '1) return '0;
                      else return $signed(x) % $signed(y);
            MDU_DIVU: return (y == 0) ? '1 : x / y;
            MDU_REMU: return (y == 0) ? x : x % y;
            MDU_MULW: begin r32 = x32 * y32; wide = 1'b0; end
            MDU_DIVW: begin
                wide = 1'b0;
                if (y32 == 0) r32 = '1;
                else if (x32 == 32'h8000_0000 && y32 == '1) r32 = x32;
                else r32 = $signed(x32) / $signed(y32);
            end
            MDU_REMW: begin
                wide = 1'b0;
                if (y32 == 0) r32 = x32;
                else if (x32 == 32'h8000_0000 && y32 == '1) r32 = '0;
                else r32 = $signed(x32) % $signed(y32);
            end
            MDU_DIVUW: begin wide = 1'b0; r32 = (y32 == 0) ? '1 : x32 / y32; end
            MDU_REMUW: begin wide = 1'b0; r32 = (y32 == 0) ? x32 : x32 % y32; end
            default: ;
        endcase
        if (wide) return '0;
        return {{32{r32[31]}}, r32};
    endfunction

    function automatic int latency(input mdu_op_t o, input word_t x, input word_t y);
        case (o)
            MDU_MUL:  return 65;
            MDU_MULW: return 33;
            MDU_DIVU, MDU_REMU: return (y == 0) ? 1 : 65;
            MDU_DIV, MDU_REM:
                return (y == 0 || (x == 64'h8000_0000_0000_0000 && y == '1)) ? 1 : 65;
            MDU_DIVUW, MDU_REMUW: return (y[31:0] == 0) ? 1 : 33;
            MDU_DIVW, MDU_REMW:
                return (y[31:0] == 0 || (x[31:0] == 32'h8000_0000 && y[31:0] == '1)) ? 1 : 33;
            default: return 0;
        endcase
    endfunction

    // Per-cycle comparison against the model's schedule.
    always @(negedge clk) begin
        if (chk_en) begin
            if (cyc == exp_done_cyc)  model_result = pending;
            if (cyc == exp_reset_cyc) model_result = '0;
            chk("done",   64'(done),  64'(cyc == exp_done_cyc));
            chk("ready",  64'(ready), 64'(cyc >= exp_ready_cyc));
            chk("busy",   64'(busy),  64'(cyc < exp_ready_cyc));
            chk("result", result, model_result);
        end
    end

    // Drives valid for the current cycle; caller must be just after a negedge.
    task automatic issue_now(input string name, input mdu_op_t o, input word_t x,
                             input word_t y, input word_t lit);
        pending = model(o, x, y);
        chk({"model_", name}, pending, lit);
        exp_done_cyc  = cyc + latency(o, x, y);
        exp_ready_cyc = exp_done_cyc + 1;
        valid = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        valid = 1'b0;
        op    = MDU_NOP;
        a     = ~x;
        b     = ~y;
    endtask

    task automatic issue(input string name, input mdu_op_t o, input word_t x,
                         input word_t y, input word_t lit);
        @(negedge clk);
        #1;
        issue_now(name, o, x, y, lit);
    endtask

    task automatic finish_op(input string name, input word_t lit);
        while (cyc < exp_ready_cyc) @(negedge clk);
        chk({"dut_", name}, result, lit);
    endtask

    task automatic run(input string name, input mdu_op_t o, input word_t x,
                       input word_t y, input word_t lit);
        issue(name, o, x, y, lit);
        finish_op(name, lit);
    endtask

    int c0;

    initial begin
        reset = 1'b1; valid = 1'b0; flush = 1'b0; op = MDU_NOP; a = '0; b = '0;
        exp_done_cyc = -1; exp_ready_cyc = 0; exp_reset_cyc = -1;
        pending = '0; model_result = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready",  64'(ready), 64'd1);
        chk("rst_busy",   64'(busy),  64'd0);
        chk("rst_done",   64'(done),  64'd0);
        chk("rst_result", result,     64'd0);
        #1 reset = 1'b0;
        chk_en = 1'b1;

        run("mul",      MDU_MUL,   64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1);
        run("mulw",     MDU_MULW,  64'h0000_0001_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE);
        run("div_neg",  MDU_DIV,   -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        run("rem_neg",  MDU_REM,   -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF);
        run("divu_z",   MDU_DIVU,  64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        run("remu_z",   MDU_REMU,  64'd100, 64'd0, 64'd100);
        run("divw_ovf", MDU_DIVW,  64'h0000_0000_8000_0000, '1, 64'hFFFF_FFFF_8000_0000);
        run("remw_ovf", MDU_REMW,  64'h0000_0000_8000_0000, '1, 64'd0);
        run("div_ovf",  MDU_DIV,   64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000);
        run("rem_ovf",  MDU_REM,   64'h8000_0000_0000_0000, '1, 64'd0);
        run("divuw",    MDU_DIVUW, 64'h1234_5678_F000_0000, 64'hABCD_0000_0000_0001, 64'hFFFF_FFFF_F000_0000);
        run("remuw",    MDU_REMUW, 64'h0000_0000_F000_0007, 64'h10, 64'd7);
        run("remw_z",   MDU_REMW,  64'h0000_0000_FFFF_FFF9, 64'h1_0000_0000, 64'hFFFF_FFFF_FFFF_FFF9);
        run("divuw_z",  MDU_DIVUW, 64'd5, 64'h7_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
        run("mul_big",  MDU_MUL,   64'h1_0000_0001, 64'h1_0000_0001, 64'h0000_0002_0000_0001);
        run("divu_big", MDU_DIVU,  '1, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF);
        run("remu_big", MDU_REMU,  '1, 64'h10, 64'hF);
        run("rem_pos",  MDU_REM,   64'd7, -64'sd2, 64'd1);
        run("div_pos",  MDU_DIV,   64'd7, -64'sd2, 64'hFFFF_FFFF_FFFF_FFFD);
        run("divw",     MDU_DIVW,  64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD);

        // NOP with valid, and flush together with valid, must not be accepted.
        @(negedge clk); #1;
        valid = 1'b1; op = MDU_NOP; a = 64'd9; b = 64'd9;
        @(negedge clk); #1;
        op = MDU_MUL; flush = 1'b1;
        @(negedge clk); #1;
        valid = 1'b0; flush = 1'b0; op = MDU_NOP;
        @(negedge clk);
        chk("ignored_result", result, 64'hFFFF_FFFF_FFFF_FFFD);

        // Flush at cycle 10 of a DIV, then a MUL issued at cycle 11 completes at cycle 76.
        @(negedge clk); #1;
        c0 = cyc;
        issue_now("div_flushed", MDU_DIV, 64'd1000, 64'd7, 64'd142);
        while (cyc < c0 + 10) @(negedge clk);
        #1;
        flush = 1'b1;
        exp_done_cyc  = -1;
        exp_ready_cyc = c0 + 11;
        @(negedge clk); #1;
        flush = 1'b0;
        chk("flush_ready", 64'(ready), 64'd1);
        issue_now("mul_after_flush", MDU_MUL, 64'd2, 64'd3, 64'd6);
        while (cyc < c0 + 76) @(negedge clk);
        chk("flush_mul_done76", 64'(done), 64'd1);
        chk("flush_mul_res76",  result,    64'd6);
        finish_op("mul_after_flush", 64'd6);

        // Reset at cycle 20 of a DIV clears result and returns to ready.
        @(negedge clk); #1;
        c0 = cyc;
        issue_now("div_reset", MDU_DIV, 64'd1000, 64'd7, 64'd142);
        while (cyc < c0 + 20) @(negedge clk);
        #1;
        reset = 1'b1;
        exp_done_cyc  = -1;
        exp_ready_cyc = c0 + 21;
        exp_reset_cyc = c0 + 21;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_result", result,     64'd0);
        chk("midrst_ready",  64'(ready), 64'd1);

        run("post_reset", MDU_DIVU, 64'd1000, 64'd7, 64'd142);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog");
    end
endmodule
